mem_port_arbiter: RTL and testbench

- Shares one single-ported main memory between the CPU instruction-fetch port and the CPU data-memory port. It replaces two private memories.
- Sits between the pipeline and memory. It presents the standard READ/WRITE/BUSYWAIT handshake to each requester and to memory.
- Uses round-robin arbitration between the two requesters. Each access is latched, issued to memory, and completed with a one-cycle release.

---
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between
// the instruction-fetch port and the data-memory port.
module mem_port_arbiter #(
  parameter logic [3:0] IFETCH_READ_CODE = 4'b1010,
  parameter int         ADDR_WIDTH       = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  INSTR_MEM_READ,
  input  logic [ADDR_WIDTH-1:0] INSTR_MEM_ADDR,
  output logic [31:0]           INSTR_MEM_READ_DATA,
  output logic                  INSTR_MEM_BUSYWAIT,
  input  logic [3:0]            DATA_MEM_READ,
  input  logic [2:0]            DATA_MEM_WRITE,
  input  logic [ADDR_WIDTH-1:0] DATA_MEM_ADDR,
  input  logic [31:0]           DATA_MEM_WRITE_DATA,
  output logic [31:0]           DATA_MEM_READ_DATA,
  output logic                  DATA_MEM_BUSYWAIT,
  output logic [3:0]            MAIN_MEM_READ,
  output logic [2:0]            MAIN_MEM_WRITE,
  output logic [ADDR_WIDTH-1:0] MAIN_MEM_ADDR,
  output logic [31:0]           MAIN_MEM_WRITE_DATA,
  input  logic [31:0]           MAIN_MEM_READ_DATA,
  input  logic                  MAIN_MEM_BUSYWAIT
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  logic [1:0]            state;
  logic                  grant;
  logic                  last_grant;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [31:0]           lat_wdata;
  logic [3:0]            lat_read;
  logic [2:0]            lat_write;
  logic [31:0]           instr_rdata;
  logic [31:0]           data_rdata;

  logic i_pend;
  logic d_pend;
  logic d_wr;
  logic pick_d;
  logic in_access;
  logic in_release;

  assign i_pend = INSTR_MEM_READ;
  assign d_wr   = DATA_MEM_WRITE[2];
  assign d_pend = DATA_MEM_READ[3] | d_wr;
  // On a tie the port that was not served last wins.
  assign pick_d = d_pend & (~i_pend | (last_grant == GRANT_I));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      grant       <= GRANT_I;
      last_grant  <= GRANT_I;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_read    <= '0;
      lat_write   <= '0;
      instr_rdata <= '0;
      data_rdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_pend | d_pend) begin
            grant <= pick_d;
            state <= ACCESS;
            if (pick_d) begin
              lat_addr  <= DATA_MEM_ADDR;
              lat_wdata <= DATA_MEM_WRITE_DATA;
              lat_read  <= d_wr ? 4'b0 : DATA_MEM_READ;
              lat_write <= d_wr ? DATA_MEM_WRITE : 3'b0;
            end else begin
              lat_addr  <= INSTR_MEM_ADDR;
              lat_wdata <= '0;
              lat_read  <= IFETCH_READ_CODE;
              lat_write <= '0;
            end
          end
        end
        ACCESS: begin
          if (!MAIN_MEM_BUSYWAIT) begin
            if (lat_read[3]) begin
              if (grant == GRANT_D) data_rdata <= MAIN_MEM_READ_DATA;
              else instr_rdata <= MAIN_MEM_READ_DATA;
            end
            last_grant <= grant;
            state      <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_access  = (state == ACCESS);
  assign in_release = (state == RELEASE);

  assign MAIN_MEM_READ       = in_access ? lat_read : 4'b0;
  assign MAIN_MEM_WRITE      = in_access ? lat_write : 3'b0;
  assign MAIN_MEM_ADDR       = lat_addr;
  assign MAIN_MEM_WRITE_DATA = lat_wdata;

  assign INSTR_MEM_READ_DATA = instr_rdata;
  assign DATA_MEM_READ_DATA  = data_rdata;

  assign INSTR_MEM_BUSYWAIT = ~RESET & i_pend
                            & ~(in_release & (grant == GRANT_I));
  assign DATA_MEM_BUSYWAIT  = ~RESET & d_pend
                            & ~(in_release & (grant == GRANT_D));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed table, corner sequences and
// random traffic against a transaction-level timing model.
module tb_mem_port_arbiter;

  logic        CLK;
  logic        RESET;
  logic        INSTR_MEM_READ;
  logic [31:0] INSTR_MEM_ADDR;
  logic [31:0] INSTR_MEM_READ_DATA;
  logic        INSTR_MEM_BUSYWAIT;
  logic [3:0]  DATA_MEM_READ;
  logic [2:0]  DATA_MEM_WRITE;
  logic [31:0] DATA_MEM_ADDR;
  logic [31:0] DATA_MEM_WRITE_DATA;
  logic [31:0] DATA_MEM_READ_DATA;
  logic        DATA_MEM_BUSYWAIT;
  logic [3:0]  MAIN_MEM_READ;
  logic [2:0]  MAIN_MEM_WRITE;
  logic [31:0] MAIN_MEM_ADDR;
  logic [31:0] MAIN_MEM_WRITE_DATA;
  logic [31:0] MAIN_MEM_READ_DATA;
  logic        MAIN_MEM_BUSYWAIT;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter dut (
    .CLK(CLK),
    .RESET(RESET),
    .INSTR_MEM_READ(INSTR_MEM_READ),
    .INSTR_MEM_ADDR(INSTR_MEM_ADDR),
    .INSTR_MEM_READ_DATA(INSTR_MEM_READ_DATA),
    .INSTR_MEM_BUSYWAIT(INSTR_MEM_BUSYWAIT),
    .DATA_MEM_READ(DATA_MEM_READ),
    .DATA_MEM_WRITE(DATA_MEM_WRITE),
    .DATA_MEM_ADDR(DATA_MEM_ADDR),
    .DATA_MEM_WRITE_DATA(DATA_MEM_WRITE_DATA),
    .DATA_MEM_READ_DATA(DATA_MEM_READ_DATA),
    .DATA_MEM_BUSYWAIT(DATA_MEM_BUSYWAIT),
    .MAIN_MEM_READ(MAIN_MEM_READ),
    .MAIN_MEM_WRITE(MAIN_MEM_WRITE),
    .MAIN_MEM_ADDR(MAIN_MEM_ADDR),
    .MAIN_MEM_WRITE_DATA(MAIN_MEM_WRITE_DATA),
    .MAIN_MEM_READ_DATA(MAIN_MEM_READ_DATA),
    .MAIN_MEM_BUSYWAIT(MAIN_MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory: busy for mem_waits cycles of each access, data from address.
  int   mem_waits = 0;
  int   mem_cnt   = 0;
  logic mem_act;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h00500093 : {a[15:0], ~a[15:0]};
  endfunction

  assign mem_act            = MAIN_MEM_READ[3] | MAIN_MEM_WRITE[2];
  assign MAIN_MEM_BUSYWAIT  = mem_act && (mem_cnt < mem_waits);
  assign MAIN_MEM_READ_DATA = mem_word(MAIN_MEM_ADDR);

  always @(posedge CLK) mem_cnt <= mem_act ? mem_cnt + 1 : 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_in();
    INSTR_MEM_READ      = 1'b0;
    INSTR_MEM_ADDR      = '0;
    DATA_MEM_READ       = '0;
    DATA_MEM_WRITE      = '0;
    DATA_MEM_ADDR       = '0;
    DATA_MEM_WRITE_DATA = '0;
  endtask

  // Called at a negedge; returns at a negedge with RESET low.
  task automatic do_reset();
    RESET = 1'b1;
    clear_in();
    mem_waits = 0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  typedef struct {
    bit          i_req;
    logic [31:0] i_addr;
    logic [3:0]  d_rd;
    logic [2:0]  d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wd;
    int          waits;
    bit          exp_d;
    logic [3:0]  e_rd;
    logic [2:0]  e_wr;
    logic [31:0] e_addr;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vt[5];

  // Random-phase model state
  bit          i_on, d_on, own_d, last_d;
  logic [31:0] ia, da, dwd;
  logic [3:0]  drd, e_rd;
  logic [2:0]  dwr, e_wr;
  logic [31:0] e_addr, e_wd;
  int          next_idle, rel, gnt_c, w, kind;

  initial begin
    vt[0] = '{1'b1, 32'h0, 4'b0, 3'b0, 32'h0, 32'h0, 0,
              1'b0, 4'b1010, 3'b0, 32'h0, 32'h00500093};
    vt[1] = '{1'b0, 32'h0, 4'b0, 3'b110, 32'h100, 32'hDEADBEEF, 3,
              1'b1, 4'b0, 3'b110, 32'h100, 32'h0};
    vt[2] = '{1'b0, 32'h0, 4'b1000, 3'b0, 32'h40, 32'h0, 1,
              1'b1, 4'b1000, 3'b0, 32'h40, 32'h0040FFBF};
    vt[3] = '{1'b0, 32'h0, 4'b1010, 3'b101, 32'h20, 32'h12345678, 0,
              1'b1, 4'b0, 3'b101, 32'h20, 32'h0};
    vt[4] = '{1'b1, 32'h8, 4'b1010, 3'b0, 32'h44, 32'h0, 0,
              1'b1, 4'b1010, 3'b0, 32'h44, 32'h0044FFBB};

    // Reset state, with requests asserted during reset
    RESET = 1'b1;
    clear_in();
    INSTR_MEM_READ = 1'b1;
    DATA_MEM_WRITE = 3'b110;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_bw_i", INSTR_MEM_BUSYWAIT, 0);
    chk("rst_bw_d", DATA_MEM_BUSYWAIT, 0);
    chk("rst_mrd", MAIN_MEM_READ, 0);
    chk("rst_mwr", MAIN_MEM_WRITE, 0);
    chk("rst_maddr", MAIN_MEM_ADDR, 0);
    chk("rst_mwd", MAIN_MEM_WRITE_DATA, 0);
    chk("rst_irdata", INSTR_MEM_READ_DATA, 0);
    chk("rst_drdata", DATA_MEM_READ_DATA, 0);
    @(negedge CLK);
    do_reset();

    // Table of single transactions
    for (int r = 0; r < 5; r++) begin
      bit d_p, rl;
      int last_k;
      do_reset();
      d_p = vt[r].d_rd[3] | vt[r].d_wr[2];
      INSTR_MEM_READ      = vt[r].i_req;
      INSTR_MEM_ADDR      = vt[r].i_addr;
      DATA_MEM_READ       = vt[r].d_rd;
      DATA_MEM_WRITE      = vt[r].d_wr;
      DATA_MEM_ADDR       = vt[r].d_addr;
      DATA_MEM_WRITE_DATA = vt[r].d_wd;
      mem_waits           = vt[r].waits;
      last_k              = vt[r].waits + 2;
      for (int k = 0; k <= last_k; k++) begin
        if (k > 0) @(negedge CLK);
        #1;
        rl = (k == last_k);
        chk("tbl_bw_i", INSTR_MEM_BUSYWAIT,
            vt[r].i_req && !(rl && !vt[r].exp_d));
        chk("tbl_bw_d", DATA_MEM_BUSYWAIT, d_p && !(rl && vt[r].exp_d));
        if (k == 0 || rl) begin
          chk("tbl_idle_ctl", {MAIN_MEM_READ, MAIN_MEM_WRITE}, 0);
        end else begin
          chk("tbl_mrd", MAIN_MEM_READ, vt[r].e_rd);
          chk("tbl_mwr", MAIN_MEM_WRITE, vt[r].e_wr);
          chk("tbl_maddr", MAIN_MEM_ADDR, vt[r].e_addr);
          if (vt[r].e_wr[2]) chk("tbl_mwd", MAIN_MEM_WRITE_DATA, vt[r].d_wd);
        end
        if (rl && vt[r].e_rd[3]) begin
          if (vt[r].exp_d) chk("tbl_drdata", DATA_MEM_READ_DATA, vt[r].e_rdata);
          else chk("tbl_irdata", INSTR_MEM_READ_DATA, vt[r].e_rdata);
        end
      end
    end

    // Continuous tie: D, I, D, I with releases at cycles 2, 5, 8, 11
    do_reset();
    INSTR_MEM_READ = 1'b1;
    INSTR_MEM_ADDR = 32'h0;
    DATA_MEM_READ  = 4'b1010;
    DATA_MEM_ADDR  = 32'h44;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge CLK);
      #1;
      chk("rr_bw_d", DATA_MEM_BUSYWAIT, !(k == 2 || k == 8));
      chk("rr_bw_i", INSTR_MEM_BUSYWAIT, !(k == 5 || k == 11));
      if (k == 2) chk("rr_drdata", DATA_MEM_READ_DATA, 32'h0044FFBB);
      if (k == 5) chk("rr_irdata", INSTR_MEM_READ_DATA, 32'h00500093);
    end

    // Fetch withdrawn during a 3-wait access, then pending load served
    do_reset();
    INSTR_MEM_READ = 1'b1;
    INSTR_MEM_ADDR = 32'h40;
    mem_waits      = 3;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) @(negedge CLK);
      if (k == 1) begin
        INSTR_MEM_READ = 1'b0;
        INSTR_MEM_ADDR = 32'h80;
        DATA_MEM_READ  = 4'b1100;
        DATA_MEM_ADDR  = 32'h44;
      end
      if (k == 6) mem_waits = 0;
      #1;
      if (k == 0) chk("wd_bw_i0", INSTR_MEM_BUSYWAIT, 1);
      if (k >= 1) chk("wd_bw_i", INSTR_MEM_BUSYWAIT, 0);
      if (k >= 1) chk("wd_bw_d", DATA_MEM_BUSYWAIT, k != 8);
      if (k == 4) chk("wd_mrd_acc", MAIN_MEM_READ, 4'b1010);
      if (k == 4) chk("wd_maddr", MAIN_MEM_ADDR, 32'h40);
      if (k == 5) chk("wd_mrd_rel", MAIN_MEM_READ, 0);
      if (k == 5) chk("wd_irdata", INSTR_MEM_READ_DATA, 32'h0040FFBF);
      if (k == 7) chk("wd_mrd_d", MAIN_MEM_READ, 4'b1100);
      if (k == 7) chk("wd_maddr_d", MAIN_MEM_ADDR, 32'h44);
      if (k == 8) chk("wd_drdata", DATA_MEM_READ_DATA, 32'h0044FFBB);
    end

    // Reset mid-access
    do_reset();
    INSTR_MEM_READ = 1'b1;
    INSTR_MEM_ADDR = 32'h0;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) @(negedge CLK);
      if (k == 2) mem_waits = 3;
      if (k == 5) begin
        RESET         = 1'b1;
        DATA_MEM_READ = 4'b1010;
        DATA_MEM_ADDR = 32'h44;
      end
      if (k == 6) begin
        RESET     = 1'b0;
        mem_waits = 0;
      end
      #1;
      if (k == 2) chk("rm_irdata0", INSTR_MEM_READ_DATA, 32'h00500093);
      if (k == 4) chk("rm_mrd_acc", MAIN_MEM_READ, 4'b1010);
      if (k == 5) chk("rm_bw_forced", {INSTR_MEM_BUSYWAIT, DATA_MEM_BUSYWAIT}, 0);
      if (k == 6) chk("rm_ctl_drop", {MAIN_MEM_READ, MAIN_MEM_WRITE}, 0);
      if (k == 6) chk("rm_irdata_clr", INSTR_MEM_READ_DATA, 0);
      if (k == 7) chk("rm_tie_d", MAIN_MEM_ADDR, 32'h44);
      if (k == 8) chk("rm_bw_d", DATA_MEM_BUSYWAIT, 0);
      if (k == 8) chk("rm_bw_i", INSTR_MEM_BUSYWAIT, 1);
    end

    // Random traffic against a cycle-arithmetic model
    do_reset();
    i_on = 0; d_on = 0; last_d = 0; own_d = 0;
    ia = 0; da = 0; dwd = 0; drd = 0; dwr = 0;
    e_rd = 0; e_wr = 0; e_addr = 0; e_wd = 0;
    next_idle = 0; rel = -1; gnt_c = -1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      if (!i_on && $urandom_range(0, 2) == 0) begin
        i_on = 1;
        ia   = 32'($urandom_range(0, 255)) << 2;
      end
      if (!d_on && $urandom_range(0, 2) == 0) begin
        d_on = 1;
        da   = 32'($urandom_range(0, 255)) << 2;
        dwd  = $urandom;
        kind = $urandom_range(0, 2);
        drd  = (kind == 1) ? 4'b0 : {1'b1, 3'($urandom_range(0, 7))};
        dwr  = (kind == 0) ? 3'b0 : {1'b1, 2'($urandom_range(0, 3))};
      end
      INSTR_MEM_READ      = i_on;
      INSTR_MEM_ADDR      = ia;
      DATA_MEM_READ       = d_on ? drd : 4'b0;
      DATA_MEM_WRITE      = d_on ? dwr : 3'b0;
      DATA_MEM_ADDR       = da;
      DATA_MEM_WRITE_DATA = dwd;
      if (c == next_idle) begin
        if (i_on || d_on) begin
          own_d     = d_on && (!i_on || !last_d);
          last_d    = own_d;
          gnt_c     = c;
          w         = $urandom_range(0, 3);
          mem_waits = w;
          rel       = c + 2 + w;
          next_idle = rel + 1;
          if (own_d) begin
            e_rd = dwr[2] ? 4'b0 : drd;
            e_wr = dwr;
            e_addr = da;
            e_wd = dwd;
          end else begin
            e_rd = 4'b1010;
            e_wr = 3'b0;
            e_addr = ia;
            e_wd = 0;
          end
        end else begin
          next_idle = c + 1;
        end
      end
      #1;
      chk("rnd_bw_i", INSTR_MEM_BUSYWAIT, i_on && !(c == rel && !own_d));
      chk("rnd_bw_d", DATA_MEM_BUSYWAIT, d_on && !(c == rel && own_d));
      if (c > gnt_c && c < rel) begin
        chk("rnd_mrd", MAIN_MEM_READ, e_rd);
        chk("rnd_mwr", MAIN_MEM_WRITE, e_wr);
        chk("rnd_maddr", MAIN_MEM_ADDR, e_addr);
        if (e_wr[2]) chk("rnd_mwd", MAIN_MEM_WRITE_DATA, e_wd);
      end else begin
        chk("rnd_idle_ctl", {MAIN_MEM_READ, MAIN_MEM_WRITE}, 0);
      end
      if (c == rel) begin
        if (e_rd[3]) begin
          if (own_d) chk("rnd_drdata", DATA_MEM_READ_DATA, mem_word(e_addr));
          else chk("rnd_irdata", INSTR_MEM_READ_DATA, mem_word(e_addr));
        end
        if (own_d) d_on = 0;
        else i_on = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
